// File: rtl/matmul_ext_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_ext_loader_pkg
// Brief    : Shared sizes, word-width macro and FSM encoding for the loader.
// Revision : 1.0
// ============================================================================

`ifndef MATMUL_WORD_W
`define MATMUL_WORD_W(size, width) ((size) * (width))
`endif

package matmul_ext_loader_pkg;

  localparam int c_dwidth_def       = 8;
  localparam int c_awidth_def       = 11;
  localparam int c_mat_mul_size_def = 4;
  localparam int c_cnt_width_def    = 8;
  localparam int c_timeout_cyc_def  = 4096;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] c_st_idle   = 3'd0;
  localparam logic [STATE_W-1:0] c_st_load_a = 3'd1;
  localparam logic [STATE_W-1:0] c_st_load_b = 3'd2;
  localparam logic [STATE_W-1:0] c_st_start  = 3'd3;
  localparam logic [STATE_W-1:0] c_st_wait   = 3'd4;
  localparam logic [STATE_W-1:0] c_st_drain  = 3'd5;
  localparam logic [STATE_W-1:0] c_st_clear  = 3'd6;

endpackage

`default_nettype wire

// File: rtl/matmul_loader_skid.sv
`default_nettype none
// ============================================================================
// Module   : matmul_loader_skid
// Brief    : Two-entry FIFO catching BRAM C read data, with occupancy output.
// Revision : 1.0
// ============================================================================
module matmul_loader_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // Pushing into a full FIFO is only legal when a pop frees a slot that cycle.
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid     = (r_count != 2'd0);
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/matmul_ext_loader.sv
`default_nettype none
// ============================================================================
// Module   : matmul_ext_loader
// Brief    : Port-1 host engine: load A/B, kick compute, drain C, clear done.
//            Optional WAIT watchdog enabled by defining MATMUL_LOADER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module matmul_ext_loader
  import matmul_ext_loader_pkg::*;
#(
  parameter int DWIDTH       = c_dwidth_def,
  parameter int AWIDTH       = c_awidth_def,
  parameter int MAT_MUL_SIZE = c_mat_mul_size_def,
  parameter int CNT_WIDTH    = c_cnt_width_def,
  parameter int TIMEOUT_CYC  = c_timeout_cyc_def
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           go,
  input  logic [AWIDTH-1:0]                              base_a,
  input  logic [AWIDTH-1:0]                              base_b,
  input  logic [AWIDTH-1:0]                              base_c,
  input  logic [7:0]                                     stride,
  input  logic [CNT_WIDTH-1:0]                           num_rows,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           error,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] in_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] out_data,
  output logic [AWIDTH-1:0]                              bram_addr_a_ext,
  output logic [AWIDTH-1:0]                              bram_addr_b_ext,
  output logic [AWIDTH-1:0]                              bram_addr_c_ext,
  output logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] bram_wdata_a_ext,
  output logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] bram_wdata_b_ext,
  output logic [MAT_MUL_SIZE-1:0]                        bram_we_a_ext,
  output logic [MAT_MUL_SIZE-1:0]                        bram_we_b_ext,
  input  logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] bram_rdata_c_ext,
  output logic [`MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH)-1:0] bram_wdata_c_ext,
  output logic [MAT_MUL_SIZE-1:0]                        bram_we_c_ext,
  output logic                                           start_reg,
  output logic                                           clear_done_reg,
  input  logic                                           done_mat_mul
);

  localparam int WORD_W = `MATMUL_WORD_W(MAT_MUL_SIZE, DWIDTH);

  logic [STATE_W-1:0]      r_state;
  logic [STATE_W-1:0]      w_next_state;

  logic [AWIDTH-1:0]       r_addr;
  logic [AWIDTH-1:0]       r_stride;
  logic [AWIDTH-1:0]       r_base_b;
  logic [AWIDTH-1:0]       r_base_c;
  logic [CNT_WIDTH-1:0]    r_num_rows;
  logic [CNT_WIDTH-1:0]    r_row;
  logic [CNT_WIDTH-1:0]    r_popped;
  logic                    r_zero_done;

  logic [AWIDTH-1:0]       r_addr_a;
  logic [AWIDTH-1:0]       r_addr_b;
  logic [AWIDTH-1:0]       r_addr_c;
  logic [WORD_W-1:0]       r_wdata_a;
  logic [WORD_W-1:0]       r_wdata_b;
  logic [MAT_MUL_SIZE-1:0] r_we_a;
  logic [MAT_MUL_SIZE-1:0] r_we_b;

  logic                    r_rd_p1;
  logic                    r_rd_p2;

  logic                    w_busy;
  logic                    w_in_ready;
  logic                    w_start;
  logic                    w_clear;
  logic                    w_drain;
  logic                    w_wr_fire;
  logic                    w_last_row;
  logic                    w_last_pop;
  logic                    w_rd_issue;
  logic                    w_pop;
  logic                    w_timeout;
  logic                    w_fifo_valid;
  logic [1:0]              w_fifo_count;
  logic [2:0]              w_occupancy;
  logic [WORD_W-1:0]       w_fifo_head;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (go && (num_rows != '0)) w_next_state = c_st_load_a;
      c_st_load_a: if (w_wr_fire && w_last_row) w_next_state = c_st_load_b;
      c_st_load_b: if (w_wr_fire && w_last_row) w_next_state = c_st_start;
      c_st_start:  w_next_state = c_st_wait;
      c_st_wait: begin
        if (done_mat_mul) begin
          w_next_state = c_st_drain;
        end else if (w_timeout) begin
          w_next_state = c_st_clear;
        end
      end
      c_st_drain:  if (w_pop && w_last_pop) w_next_state = c_st_clear;
      c_st_clear:  w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_in_ready = 1'b0;
    w_start    = 1'b0;
    w_clear    = 1'b0;
    w_drain    = 1'b0;
    case (r_state)
      c_st_idle:                w_busy     = 1'b0;
      c_st_load_a, c_st_load_b: w_in_ready = 1'b1;
      c_st_start:               w_start    = 1'b1;
      c_st_drain:               w_drain    = 1'b1;
      c_st_clear:               w_clear    = 1'b1;
      default:                  w_busy     = 1'b1;
    endcase
  end

  // ------------------------------------------------------------- handshakes
  assign w_wr_fire   = in_valid && w_in_ready;
  assign w_last_row  = (r_row == (r_num_rows - CNT_WIDTH'(1)));
  assign w_last_pop  = (r_popped == (r_num_rows - CNT_WIDTH'(1)));
  assign w_pop       = w_fifo_valid && out_ready;

  // Reads in flight count against FIFO space so every returning word has a slot.
  assign w_occupancy = 3'(w_fifo_count) + 3'(r_rd_p1) + 3'(r_rd_p2);
  assign w_rd_issue  = w_drain && (r_row != r_num_rows) && (w_occupancy < 3'd2);

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_base_b    <= '0;
      r_base_c    <= '0;
      r_num_rows  <= '0;
      r_row       <= '0;
      r_popped    <= '0;
      r_zero_done <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      r_wdata_a   <= '0;
      r_wdata_b   <= '0;
      r_we_a      <= '0;
      r_we_b      <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      r_we_a      <= '0;
      r_we_b      <= '0;
      r_rd_p1     <= w_rd_issue;
      r_rd_p2     <= r_rd_p1;
      case (r_state)
        c_st_idle: begin
          if (go) begin
            r_addr      <= base_a;
            r_stride    <= AWIDTH'(stride);
            r_base_b    <= base_b;
            r_base_c    <= base_c;
            r_num_rows  <= num_rows;
            r_row       <= '0;
            r_popped    <= '0;
            r_zero_done <= (num_rows == '0);
          end
        end
        c_st_load_a, c_st_load_b: begin
          if (w_wr_fire) begin
            if (r_state == c_st_load_a) begin
              r_addr_a  <= r_addr;
              r_wdata_a <= in_data;
              r_we_a    <= '1;
            end else begin
              r_addr_b  <= r_addr;
              r_wdata_b <= in_data;
              r_we_b    <= '1;
            end
            // The running address hops to the next matrix base on the last row.
            if (w_last_row) begin
              r_row  <= '0;
              r_addr <= (r_state == c_st_load_a) ? r_base_b : r_base_c;
            end else begin
              r_row  <= r_row + CNT_WIDTH'(1);
              r_addr <= r_addr + r_stride;
            end
          end
        end
        c_st_drain: begin
          if (w_rd_issue) begin
            r_addr_c <= r_addr;
            r_addr   <= r_addr + r_stride;
            r_row    <= r_row + CNT_WIDTH'(1);
          end
          if (w_pop) begin
            r_popped <= r_popped + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_row <= r_row;
        end
      endcase
    end
  end

  // --------------------------------------------------------------- watchdog
`ifdef MATMUL_LOADER_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_to_w-1:0] r_wait_cnt;
  logic              r_error;

  always_ff @(posedge clk) begin
    if (reset || (r_state != c_st_wait)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + c_to_w'(1);
    end
  end

  assign w_timeout = (r_state == c_st_wait) && !done_mat_mul &&
                     (r_wait_cnt == c_to_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((r_state == c_st_idle) && go) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
  assign error            = 1'b0;
`endif

  // ----------------------------------------------------------- C read FIFO
  matmul_loader_skid #(
    .WIDTH (WORD_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (r_rd_p2),
    .push_data (bram_rdata_c_ext),
    .pop       (w_pop),
    .valid     (w_fifo_valid),
    .head_data (w_fifo_head),
    .count     (w_fifo_count)
  );

  // ---------------------------------------------------------------- outputs
  assign busy             = w_busy;
  assign done             = w_clear || r_zero_done;
  assign in_ready         = w_in_ready;
  assign out_valid        = w_fifo_valid;
  assign out_data         = w_fifo_head;
  assign start_reg        = w_start;
  assign clear_done_reg   = w_clear;
  assign bram_addr_a_ext  = r_addr_a;
  assign bram_addr_b_ext  = r_addr_b;
  assign bram_addr_c_ext  = r_addr_c;
  assign bram_wdata_a_ext = r_wdata_a;
  assign bram_wdata_b_ext = r_wdata_b;
  assign bram_we_a_ext    = r_we_a;
  assign bram_we_b_ext    = r_we_b;
  assign bram_wdata_c_ext = '0;
  assign bram_we_c_ext    = '0;

endmodule

`default_nettype wire
